// File: rtl/pe_fp8_dot_pipe.sv
// ============================================================================
//  Module   : pe_fp8_dot_pipe
//  Brief    : Multi-lane FP8 (E4M3/E5M2) dot-product PE. It has a 2-stage
//             BF16 accumulate pipeline and a per-column result drain chain.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pe_fp8_dot_pipe #(
    parameter int LANES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fmt,
    input  logic                 in_valid,
    input  logic                 in_clear,
    input  logic                 in_last,
    input  logic [8*LANES-1:0]   a_in,
    input  logic [8*LANES-1:0]   b_in,
    output logic [8*LANES-1:0]   a_out,
    output logic [8*LANES-1:0]   b_out,
    output logic                 out_valid,
    output logic                 out_clear,
    output logic                 out_last,
    output logic                 fmt_out,
    output logic [15:0]          acc_out,
    input  logic [15:0]          res_in,
    input  logic                 res_in_valid,
    input  logic                 res_shift,
    output logic [15:0]          res_out,
    output logic                 res_valid
);

    // FP8 x FP8 -> BF16. The product is exact because 4x4 significand bits fit in BF16.
    // E5M2 significands are padded to 4 bits, so both formats share one multiplier path.
    function automatic logic [15:0] fp8_mul(input logic [7:0] a, input logic [7:0] b,
                                            input logic f);
        logic [4:0] ea, eb;
        logic [3:0] sa, sb;
        logic [7:0] p;
        logic [8:0] e;
        logic [6:0] m;
        ea = f ? a[6:2] : {1'b0, a[6:3]};
        eb = f ? b[6:2] : {1'b0, b[6:3]};
        sa = f ? {1'b1, a[1:0], 1'b0} : {1'b1, a[2:0]};
        sb = f ? {1'b1, b[1:0], 1'b0} : {1'b1, b[2:0]};
        p  = {4'b0, sa} * {4'b0, sb};
        // 127 - 2*bias: 113 for E4M3, 97 for E5M2. The result cannot leave the BF16 normal range.
        e  = {4'b0, ea} + {4'b0, eb} + (f ? 9'd97 : 9'd113) + {8'b0, p[7]};
        m  = p[7] ? p[6:0] : {p[5:0], 1'b0};
        if (ea == 5'd0 || eb == 5'd0)
            return 16'h0000;
        return {a[7] ^ b[7], e[7:0], m};
    endfunction

    // BF16 add. The smaller operand is aligned with 3 guard bits plus a sticky bit.
    // Rounding is round-to-nearest-even. Overflow saturates, and underflow flushes to +0.
    function automatic logic [15:0] bf16_add(input logic [15:0] x, input logic [15:0] y);
        logic [15:0]       big, sml;
        logic [7:0]        d8;
        logic [4:0]        d;
        logic [39:0]       sh;
        logic [11:0]       mb, ms, n;
        logic [12:0]       r;
        logic signed [9:0] e;
        logic [3:0]        lz;
        logic              found, rup;
        logic [7:0]        mant;
        if (x[14:7] == 8'd0)
            return y;
        if (y[14:7] == 8'd0)
            return x;
        if (x[14:0] >= y[14:0]) begin
            big = x;
            sml = y;
        end else begin
            big = y;
            sml = x;
        end
        d8 = big[14:7] - sml[14:7];
        // Any shift of 31 or more lands wholly in the sticky region, so clamping is lossless.
        d  = (d8 > 8'd31) ? 5'd31 : d8[4:0];
        sh = {1'b1, sml[6:0], 32'b0} >> d;
        mb = {1'b1, big[6:0], 4'b0};
        ms = {sh[39:29], |sh[28:0]};
        if (big[15] == sml[15])
            r = {1'b0, mb} + {1'b0, ms};
        else
            r = {1'b0, mb} - {1'b0, ms};
        if (r == 13'd0)
            return 16'h0000;
        e = $signed({2'b00, big[14:7]});
        if (r[12]) begin
            n = {r[12:2], r[1] | r[0]};
            e = e + 10'sd1;
        end else begin
            lz    = 4'd0;
            found = 1'b0;
            for (int i = 11; i >= 0; i--) begin
                if (!found) begin
                    if (r[i])
                        found = 1'b1;
                    else
                        lz = lz + 4'd1;
                end
            end
            n = r[11:0] << lz;
            e = e - $signed({6'b0, lz});
        end
        rup  = n[3] & (n[4] | (|n[2:0]));
        mant = {1'b0, n[10:4]} + {7'b0, rup};
        if (mant[7])
            e = e + 10'sd1;
        if (e >= 10'sd255)
            return {big[15], 15'h7F7F};
        if (e <= 10'sd0)
            return 16'h0000;
        return {big[15], e[7:0], mant[6:0]};
    endfunction

    logic [15:0] w_prod [LANES];
    logic [15:0] r_prod [LANES];
    logic        r_s1_valid;
    logic        r_s1_clear;
    logic        r_s1_last;
    logic [15:0] r_acc;
    logic [15:0] w_new;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign w_prod[gi] = fp8_mul(a_in[8*gi +: 8], b_in[8*gi +: 8], fmt);
    end

    // Systolic forwarding of operands and flags, registered every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_out     <= '0;
            b_out     <= '0;
            out_valid <= 1'b0;
            out_clear <= 1'b0;
            out_last  <= 1'b0;
            fmt_out   <= 1'b0;
        end else begin
            a_out     <= a_in;
            b_out     <= b_in;
            out_valid <= in_valid;
            out_clear <= in_clear;
            out_last  <= in_last;
            fmt_out   <= fmt;
        end
    end

    // Stage 1: register the lane products and the beat flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_clear <= 1'b0;
            r_s1_last  <= 1'b0;
            for (int i = 0; i < LANES; i++)
                r_prod[i] <= 16'h0000;
        end else begin
            r_s1_valid <= in_valid;
            r_s1_clear <= in_clear;
            r_s1_last  <= in_last;
            for (int i = 0; i < LANES; i++)
                r_prod[i] <= w_prod[i];
        end
    end

    // Stage 2 datapath: add the lanes left to right, rounding after each addition
    always_comb begin
        w_new = r_s1_clear ? 16'h0000 : r_acc;
        for (int i = 0; i < LANES; i++)
            w_new = bf16_add(w_new, r_prod[i]);
    end

    // Accumulator update on each valid stage-2 beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_acc <= 16'h0000;
        else if (r_s1_valid)
            r_acc <= w_new;
    end

    // Result capture has priority over the drain-chain shift
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_out   <= 16'h0000;
            res_valid <= 1'b0;
        end else if (r_s1_valid && r_s1_last) begin
            res_out   <= w_new;
            res_valid <= 1'b1;
        end else if (res_shift) begin
            res_out   <= res_in;
            res_valid <= res_in_valid;
        end
    end

    assign acc_out = r_acc;

endmodule

`default_nettype wire
